snap_capture_ctrl: RTL

- Write-side controller for a 64-bit-wide snapshot BRAM. It drives the BRAM's port A: write strobe, enable, 9-bit address and 64-bit write data.
- Software arms it. Then, on a trigger, it records consecutive valid input words into the BRAM.
- Capture ends at full depth or on an early stop. Status is reported for the register interface, and the CPU reads the captured words back through the BRAM's 32-bit port B.

---
 rtl/snap_capture_ctrl_if.sv | 25 ++
 rtl/snap_capture_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/snap_capture_ctrl_if.sv
// BRAM port A write bundle between the snapshot capture controller (master)
// and the snapshot BRAM (slave).
interface snap_capture_ctrl_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 9
);
   logic              bram_we;
   logic              bram_en_a;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wr_data;

   modport master (
      output bram_we,
      output bram_en_a,
      output bram_addr,
      output bram_wr_data
   );

   modport slave (
      input bram_we,
      input bram_en_a,
      input bram_addr,
      input bram_wr_data
   );
endinterface

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: software arms it, a trigger starts recording
// consecutive valid input words into a 2^ADDR_W-deep BRAM through port A, and
// capture ends at full depth or on an early stop. Writes reach the BRAM one
// cycle after the word is accepted.
module snap_capture_ctrl #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    arm,
   input  logic                    trig,
   input  logic                    stop,
   input  logic [DATA_W-1:0]       din,
   input  logic                    din_we,
   snap_capture_ctrl_if.master     bram,
   output logic                    busy,
   output logic                    done,
   output logic [ADDR_W:0]         count
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // Count value just before the write that fills the last address.
   localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              arm_q, arm_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              arm_rise;
   logic              accept;

   assign arm_rise = arm & ~arm_q;
   assign arm_d    = arm;

   // Next-state, count and write-stage computation for one clock.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      accept  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arm_rise) begin
               state_d = ST_ARMED;
               count_d = '0;
            end
         end
         ST_ARMED: begin
            // A trigger only counts when it coincides with a valid word.
            if (trig && din_we) begin
               accept  = 1'b1;
               state_d = ST_CAPTURE;
            end else if (stop) begin
               state_d = ST_DONE;
            end
         end
         ST_CAPTURE: begin
            if (din_we) begin
               accept = 1'b1;
            end else if (stop) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (arm_rise) begin
               state_d = ST_ARMED;
               count_d = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // An accepted word is written at the pre-increment count; a stop on the
      // same cycle still keeps that word.
      if (accept) begin
         we_d    = 1'b1;
         addr_d  = count_q[ADDR_W-1:0];
         wdata_d = din;
         count_d = count_q + (ADDR_W+1)'(1);
         if (count_q == LAST_CNT || stop) begin
            state_d = ST_DONE;
         end
      end
   end

   // Control and write-stage registers; reset aborts any capture in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         arm_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         arm_q   <= arm_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bram.bram_we      = we_q;
   assign bram.bram_en_a    = we_q;
   assign bram.bram_addr    = addr_q;
   assign bram.bram_wr_data = wdata_q;

   assign busy  = (state_q == ST_ARMED) | (state_q == ST_CAPTURE);
   assign done  = (state_q == ST_DONE);
   assign count = count_q;

endmodule
